spike_event_logger: RTL and testbench
=====================================

Name: spike_event_logger

Overview:
- Consumer end of the NN classifier output stream: samples the 2-bit class word on every cycle the NN flags its output valid, timestamps it, and turns non-zero detections into spike events.
- Applies a per-class refractory window to merge repeated detections of one spike.
- Buffers events in an on-chip FIFO for a host-side reader.
- Replaces file logging of NN_out with a synthesizable on-chip result path.

Parameters:
- TS_WIDTH, 16, width of the sample timestamp counter and of the event timestamp field.
- DEPTH, 16, FIFO depth in events; must be a power of 2, minimum 2.
- REFRACT, 8, valid samples after an event during which same-class detections are suppressed; 0 disables suppression.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- nn_out  in  2  NN class word; 0 = no spike, 1..3 = spike class.
- nn_valid  in  1  nn_out is a valid sample this cycle.
- rd_en  in  1  host pop request.
- clr_ovf  in  1  synchronous clear of ovf and drop_cnt.
- rd_data  out  TS_WIDTH+2  popped event {class[1:0], timestamp}.
- rd_valid  out  1  rd_data valid; single-cycle pulse.
- empty  out  1  FIFO holds no events.
- full  out  1  FIFO holds DEPTH events.
- level  out  log2(DEPTH)+1  current event count.
- ovf  out  1  sticky: at least one event dropped.
- drop_cnt  out  8  dropped events, saturating at 255.

Behaviour:
- Reset (rst=0, asynchronous):
  - ts=0; state IDLE; refractory counter=0; last_class=0; FIFO pointers=0.
  - rd_data=0, rd_valid=0, empty=1, full=0, level=0, ovf=0, drop_cnt=0.
  - Reset mid-operation discards all buffered events.
- Timestamp:
  - ts increments by 1 on every cycle with nn_valid=1 and wraps from 2^TS_WIDTH-1 to 0.
  - An event carries ts before the increment, i.e. the index of its own sample.
- Detection state machine, evaluated only on cycles with nn_valid=1:
  - IDLE, nn_out!=0: push {nn_out, ts}; last_class=nn_out. If REFRACT>0: load rcnt=REFRACT, go to HOLD; otherwise stay in IDLE.
  - IDLE, nn_out==0: no action.
  - HOLD, nn_out==last_class: suppressed, no push.
  - HOLD, nn_out!=0 and nn_out!=last_class: push; last_class=nn_out; rcnt=REFRACT; stay in HOLD.
  - HOLD, any other sample that is not a new push: rcnt decrements; when rcnt reaches 0, go to IDLE.
  - Net effect: samples n+1..n+REFRACT of the event's class are suppressed; sample n+REFRACT+1 is eligible again.
  - Cycles with nn_valid=0 change neither state nor rcnt.
- FIFO write:
  - A push is written on the same clock edge; empty falls and level rises on the following cycle.
  - Push while full with no simultaneous pop: event dropped, ovf set, drop_cnt+1 (saturating at 255).
  - Push and pop in the same cycle while full: the pop frees the slot, the push is accepted, full stays 1, no drop.
  - Push and pop in the same cycle while empty: the pop is ignored and the push is accepted; bypass is not supported.
- FIFO read:
  - rd_en=1 with empty=0: rd_data is registered and rd_valid=1 on the next cycle (1-cycle latency).
  - rd_en=1 with empty=1: ignored; rd_valid stays 0 and rd_data holds its previous value.
- Clear:
  - clr_ovf=1 clears ovf and drop_cnt at the next edge.
  - A drop in the same cycle as clr_ovf wins: ovf=1 and drop_cnt=1.
- Pointers: log2(DEPTH)+1 bits, wrap naturally; full and empty are derived from the MSB/LSB comparison.

Decomposition:
- Shared package (spike_pkg):
  - class encodings: CLS_NONE=2'd0, CLS_1..CLS_3.
  - EVT_W = TS_WIDTH+2.
  - FSM state encoding: IDLE, HOLD.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop, registered read data, full/empty/level.
- The parent keeps the timestamp counter, refractory FSM, drop accounting and clear logic.

Test Plan:
- Reset, then classes 0,0,2,0 with nn_valid=1 -> one event {2, ts=2}; empty falls the following cycle; rd_en returns rd_data={2'd2,16'd2} with rd_valid=1 one cycle later.
- REFRACT=8: class 1 at sample 10, class 1 on samples 11-18 and again at 19 -> events at ts=10 and ts=19 only.
- Class 1 at sample 5, then class 3 at sample 7 (inside HOLD) -> both events pushed; class 3 suppressed through sample 15.
- nn_valid toggling 1/0 with class 1 every valid sample -> gap cycles add no ts increment and no rcnt decrement; event spacing is 9 valid samples.
- DEPTH=16: 18 separated events with no reads -> full=1, ovf=1, drop_cnt=2; a 17th push on the same cycle as a pop -> accepted, drop_cnt unchanged; clr_ovf -> ovf=0, drop_cnt=0.
- ts preset near 16'hFFFF, then events at 16'hFFFF and 16'h0009 -> correct wrapped timestamps; rst asserted with 5 events buffered -> empty=1, level=0, ts=0 immediately.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared types and helpers for the spike event logger.
package spike_pkg;

  // NN class word; zero means no spike on this sample.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_1    = 2'd1,
    CLS_2    = 2'd2,
    CLS_3    = 2'd3
  } cls_e;

  // Refractory detector states.
  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  // Event word width: {class[1:0], timestamp}.
  function automatic int unsigned evt_w(input int unsigned ts_width);
    return ts_width + 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and extra-MSB pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A pop on an empty FIFO is ignored; a pop frees a slot for a push while full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers, registered read data and the one-cycle read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
    end else begin
      rvalid <= do_pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata    <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spike_event_logger.sv
// Timestamps NN class samples, merges repeats with a refractory window and
// buffers the resulting spike events for a host reader.
module spike_event_logger
  import spike_pkg::*;
#(
  parameter int unsigned TS_WIDTH = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned REFRACT  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  nn_out,
  input  logic                        nn_valid,
  input  logic                        rd_en,
  input  logic                        clr_ovf,
  output logic [evt_w(TS_WIDTH)-1:0]  rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        ovf,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned EVT_W = evt_w(TS_WIDTH);
  localparam int unsigned RW    = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  state_e              state_q, state_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  cls_e                last_q, last_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_q, drop_d;
  logic                push, drop;
  cls_e                cls_in;

  assign cls_in = cls_e'(nn_out);

  // Detector next state: only valid samples advance the FSM or the window.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    last_d  = last_q;
    push    = 1'b0;
    if (nn_valid) begin
      unique case (state_q)
        StIdle: begin
          if (cls_in != CLS_NONE) begin
            push   = 1'b1;
            last_d = cls_in;
            if (REFRACT > 0) begin
              rcnt_d  = RW'(REFRACT);
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (cls_in != CLS_NONE && cls_in != last_q) begin
            push   = 1'b1;
            last_d = cls_in;
            rcnt_d = RW'(REFRACT);
          end else begin
            rcnt_d = rcnt_q - RW'(1);
            if (rcnt_q == RW'(1)) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Timestamp and drop accounting; a drop coinciding with a clear still counts.
  always_comb begin
    ts_d   = ts_q + TS_WIDTH'(nn_valid);
    drop   = push & full & ~rd_en;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1);
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q    <= '0;
      state_q <= StIdle;
      rcnt_q  <= '0;
      last_q  <= CLS_NONE;
      ovf_q   <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      ts_q    <= ts_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (rd_en),
    .wdata  ({nn_out, ts_q}),
    .rdata  (rd_data),
    .rvalid (rd_valid),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

endmodule

// File: tb/tb_spike_event_logger.sv
// Self-checking bench: vector table plus scoreboard of expected events.
module tb_spike_event_logger;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  nn_out = 2'd0;
  logic        nn_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [17:0] rd_data;
  logic        rd_valid, empty, full, ovf;
  logic [4:0]  level;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // exp: 0 = no event, 1 = event accepted, 2 = event dropped
  typedef struct {
    logic       v;
    logic [1:0] cls;
    logic [1:0] exp;
    logic       drain;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] sb[$];
  logic [15:0] exp_ts = 16'd0;

  always #5 clk = ~clk;

  spike_event_logger dut (
    .clk      (clk),
    .rst      (rst),
    .nn_out   (nn_out),
    .nn_valid (nn_valid),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [1:0] c, input logic [1:0] e);
    vecs.push_back('{v: v, cls: c, exp: e, drain: 1'b0});
  endfunction

  function automatic void add_drain();
    vecs.push_back('{v: 1'b0, cls: 2'd0, exp: 2'd0, drain: 1'b1});
  endfunction

  function automatic void add_pad();
    for (int i = 0; i < 10; i++) add(1'b1, 2'd0, 2'd0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t);
    nn_valid = t.v;
    nn_out   = t.cls;
    if (t.exp == 2'd1) sb.push_back({t.cls, exp_ts});
    step();
    nn_valid = 1'b0;
    nn_out   = 2'd0;
    if (t.v) exp_ts = exp_ts + 16'd1;
  endtask

  // Pop every expected event, then confirm a read on empty is ignored.
  task automatic drain(input string tag);
    logic [17:0] e;
    logic [17:0] last;
    bit          any = 1'b0;
    int          guard = 0;
    while (sb.size() > 0 && guard < 64) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      e = sb.pop_front();
      check({tag, " rd_valid"}, 64'(rd_valid), 64'd1);
      check({tag, " rd_data"}, 64'(rd_data), 64'(e));
      last = e;
      any  = 1'b1;
      guard++;
    end
    if (guard >= 64) check({tag, " drain bound"}, 64'(guard), 64'd0);
    check({tag, " empty after drain"}, 64'(empty), 64'd1);
    if (any) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check({tag, " rd_valid on empty read"}, 64'(rd_valid), 64'd0);
      check({tag, " rd_data holds"}, 64'(rd_data), 64'(last));
    end
  endtask

  initial begin
    logic [17:0] e;

    // Reset values
    #12;
    check("reset rd_data", 64'(rd_data), 64'd0);
    check("reset rd_valid", 64'(rd_valid), 64'd0);
    check("reset empty", 64'(empty), 64'd1);
    check("reset full", 64'(full), 64'd0);
    check("reset level", 64'(level), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    check("reset drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Classes 0,0,2,0: one event {2, ts=2}
    apply('{v: 1'b1, cls: 2'd0, exp: 2'd0, drain: 1'b0});
    apply('{v: 1'b1, cls: 2'd0, exp: 2'd0, drain: 1'b0});
    check("A empty before push", 64'(empty), 64'd1);
    apply('{v: 1'b1, cls: 2'd2, exp: 2'd1, drain: 1'b0});
    check("A empty falls", 64'(empty), 64'd0);
    check("A level", 64'(level), 64'd1);
    apply('{v: 1'b1, cls: 2'd0, exp: 2'd0, drain: 1'b0});
    check("A expected ts", 64'(sb[0]), 64'({2'd2, 16'd2}));
    drain("A");
    for (int i = 0; i < 10; i++) apply('{v: 1'b1, cls: 2'd0, exp: 2'd0, drain: 1'b0});

    // Same class repeated: window of 8 suppressed samples
    add(1, 1, 1);
    for (int i = 0; i < 8; i++) add(1, 1, 0);
    add(1, 1, 1);
    add_pad();
    add_drain();
    // Different class inside the window restarts it for the new class
    add(1, 1, 1);
    add(1, 0, 0);
    add(1, 3, 1);
    for (int i = 0; i < 8; i++) add(1, 3, 0);
    add(1, 3, 1);
    add_pad();
    add_drain();
    // Gap cycles freeze ts and the window
    add(1, 1, 1);
    add(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      add(1, 1, 0);
      add(0, 1, 0);
    end
    add(1, 1, 1);
    add_pad();
    add_drain();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].drain) drain($sformatf("table%0d", i));
      else apply(vecs[i]);
    end

    // Overflow: 18 back-to-back events of alternating class, no reads
    for (int i = 0; i < 18; i++)
      apply('{v: 1'b1, cls: (i % 2 == 1) ? 2'd2 : 2'd1,
              exp: (i < 16) ? 2'd1 : 2'd2, drain: 1'b0});
    check("E full", 64'(full), 64'd1);
    check("E level", 64'(level), 64'd16);
    check("E ovf", 64'(ovf), 64'd1);
    check("E drop_cnt", 64'(drop_cnt), 64'd2);

    // Push and pop together while full: accepted, no drop
    e = sb.pop_front();
    sb.push_back({2'd1, exp_ts});
    nn_valid = 1'b1;
    nn_out   = 2'd1;
    rd_en    = 1'b1;
    step();
    nn_valid = 1'b0;
    nn_out   = 2'd0;
    rd_en    = 1'b0;
    exp_ts   = exp_ts + 16'd1;
    check("E pop rd_valid", 64'(rd_valid), 64'd1);
    check("E pop rd_data", 64'(rd_data), 64'(e));
    check("E full after push+pop", 64'(full), 64'd1);
    check("E drop_cnt unchanged", 64'(drop_cnt), 64'd2);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("E clr ovf", 64'(ovf), 64'd0);
    check("E clr drop_cnt", 64'(drop_cnt), 64'd0);

    // Drop coinciding with clear: drop wins
    nn_valid = 1'b1;
    nn_out   = 2'd2;
    clr_ovf  = 1'b1;
    step();
    nn_valid = 1'b0;
    nn_out   = 2'd0;
    clr_ovf  = 1'b0;
    exp_ts   = exp_ts + 16'd1;
    check("E drop+clr ovf", 64'(ovf), 64'd1);
    check("E drop+clr drop_cnt", 64'(drop_cnt), 64'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("E second clr drop_cnt", 64'(drop_cnt), 64'd0);
    drain("E");
    for (int i = 0; i < 10; i++) apply('{v: 1'b1, cls: 2'd0, exp: 2'd0, drain: 1'b0});

    // Timestamp wrap: events at 16'hFFFF and 16'h0009
    while (exp_ts != 16'hFFFF) apply('{v: 1'b1, cls: 2'd0, exp: 2'd0, drain: 1'b0});
    apply('{v: 1'b1, cls: 2'd1, exp: 2'd1, drain: 1'b0});
    for (int i = 0; i < 9; i++) apply('{v: 1'b1, cls: 2'd0, exp: 2'd0, drain: 1'b0});
    apply('{v: 1'b1, cls: 2'd1, exp: 2'd1, drain: 1'b0});
    check("F wrapped ts", 64'(sb[1]), 64'({2'd1, 16'h0009}));
    drain("F");

    // Reset with 5 events buffered discards them and restarts ts
    for (int i = 0; i < 5; i++)
      apply('{v: 1'b1, cls: (i % 2 == 1) ? 2'd3 : 2'd2, exp: 2'd0, drain: 1'b0});
    check("G level before reset", 64'(level), 64'd5);
    #2 rst = 1'b0;
    #1;
    check("G reset empty", 64'(empty), 64'd1);
    check("G reset level", 64'(level), 64'd0);
    check("G reset rd_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    exp_ts = 16'd0;
    apply('{v: 1'b1, cls: 2'd1, exp: 2'd1, drain: 1'b0});
    drain("G");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
